// File: rtl/count_capture_fifo_pkg.sv
// count_capture_pkg: width helpers and the DEPTH legality check shared by the capture FIFO.
package count_capture_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int fill_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit depth_ok(input int depth);
        return depth >= 2 && (depth & (depth - 1)) == 0;
    endfunction

endpackage

// File: rtl/count_capture_fifo_rise_edge_det.sv
// rise_edge_det: one-cycle pulse on each 0->1 transition of d.
module rise_edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic rise
);
    logic evt_d_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) evt_d_q <= 1'b0;
        else       evt_d_q <= d;
    end

    assign rise = d && !evt_d_q;
endmodule

// File: rtl/count_capture_fifo.sv
// count_capture_fifo: timestamps event rising edges with the live counter value
// and queues them for a valid/ready consumer, with a sticky overflow flag.
module count_capture_fifo
    import count_capture_pkg::*;
#(
    parameter int CNT_W = 3,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [CNT_W-1:0]          cnt_in,
    input  logic                      en,
    input  logic                      evt_in,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [CNT_W-1:0]          m_data,
    output logic [fill_w(DEPTH)-1:0]  fill,
    output logic                      ovf,
    input  logic                      clr_ovf
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int FILL_W = fill_w(DEPTH);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end

    logic [CNT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              ovf_q, ovf_d;
    logic              rise, push, pop, full, wr, drop;

    rise_edge_det u_rise (
        .clk  (clk),
        .rstn (rstn),
        .d    (evt_in),
        .rise (rise)
    );

    assign m_valid = fill_q != '0;
    assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
    assign fill    = fill_q;
    assign ovf     = ovf_q;

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        full     = fill_q == FULL;
        push     = rise && en;
        pop      = m_valid && m_ready;
        wr       = push && (!full || pop);
        drop     = push && full && !pop;
        wr_ptr_d = wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fill_d   = (wr && !pop) ? fill_q + FILL_W'(1) :
                   (pop && !wr) ? fill_q - FILL_W'(1) : fill_q;
        ovf_d    = drop || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= cnt_in;
    end
endmodule

// File: tb/tb_count_capture_fifo.sv
// tb_count_capture_fifo: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the capture FIFO.
module tb_count_capture_fifo;
    localparam int CNT_W = 3;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [CNT_W-1:0] cnt_in = '0;
    logic             en = 1'b0, evt_in = 1'b0, m_ready = 1'b0, clr_ovf = 1'b0;
    logic             m_valid, ovf;
    logic [CNT_W-1:0] m_data;
    logic [2:0]       fill;

    int tests = 0;
    int fails = 0;

    count_capture_fifo #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .cnt_in  (cnt_in),
        .en      (en),
        .evt_in  (evt_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .fill    (fill),
        .ovf     (ovf),
        .clr_ovf (clr_ovf)
    );

    always #5 clk = ~clk;

    // Model: captured values held in a plain queue, overflow as a bit.
    logic [CNT_W-1:0] mq[$];
    bit               m_prev, m_ovf;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            m_prev = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            bit push_req, dropped;
            push_req = evt_in && !m_prev && en;
            m_prev   = evt_in;
            dropped  = 1'b0;
            if (mq.size() > 0 && m_ready) void'(mq.pop_front());
            if (push_req) begin
                if (mq.size() < DEPTH) mq.push_back(cnt_in);
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            chk("model_valid", 32'(m_valid), 32'(mq.size() != 0));
            chk("model_data", 32'(m_data), mq.size() != 0 ? 32'(mq[0]) : 32'd0);
            chk("model_fill", 32'(fill), 32'(mq.size()));
            chk("model_ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    task automatic cyc(input logic e, input logic n, input logic r, input logic c, input logic [CNT_W-1:0] v);
        evt_in = e; en = n; m_ready = r; clr_ovf = c; cnt_in = v;
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 1, 1, 0, 0);
    endtask

    logic [CNT_W-1:0] ovf_vals [5] = '{3'd6, 3'd4, 3'd2, 3'd0, 3'd7};
    logic [CNT_W-1:0] exp_full [4] = '{3'd2, 3'd3, 3'd4, 3'd3};

    initial begin
        #12;
        chk("reset_valid", 32'(m_valid), 0);
        chk("reset_fill", 32'(fill), 0);
        chk("reset_ovf", 32'(ovf), 0);
        chk("reset_data", 32'(m_data), 0);
        @(negedge clk);
        #1;
        rstn = 1'b1;

        // single capture on a down-counting sequence
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 7);
        cyc(0, 1, 0, 0, 6);
        cyc(1, 1, 0, 0, 5);
        chk("single_valid", 32'(m_valid), 1);
        chk("single_data", 32'(m_data), 5);
        chk("single_fill", 32'(fill), 1);
        chk("single_ovf", 32'(ovf), 0);
        cyc(0, 1, 0, 0, 4);
        drain();

        // level hold yields one entry; disabled pulse adds none
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 3'(4 - i));
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("level_fill", 32'(fill), 1);
        chk("level_data", 32'(m_data), 4);
        drain();

        // overflow then ordered drain
        foreach (ovf_vals[i]) begin
            cyc(1, 1, 0, 0, ovf_vals[i]);
            cyc(0, 1, 0, 0, 0);
        end
        chk("ovf_fill", 32'(fill), 4);
        chk("ovf_flag", 32'(ovf), 1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_data", 32'(m_data), 32'(ovf_vals[i]));
            cyc(0, 1, 1, 0, 0);
        end
        chk("ovf_empty_valid", 32'(m_valid), 0);
        chk("ovf_empty_data", 32'(m_data), 0);
        cyc(0, 1, 0, 1, 0);
        chk("ovf_cleared", 32'(ovf), 0);

        // full push plus pop
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 1, 0, 0, 3'(i));
            cyc(0, 1, 0, 0, 0);
        end
        cyc(1, 1, 1, 0, 3);
        chk("fullpp_fill", 32'(fill), 4);
        chk("fullpp_ovf", 32'(ovf), 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("fullpp_drain", 32'(m_data), 32'(exp_full[i]));
            cyc(0, 1, 1, 0, 0);
        end
        chk("fullpp_empty", 32'(fill), 0);

        // set beats clear
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 0, 3'(i));
            cyc(0, 1, 0, 0, 0);
        end
        chk("prio_ovf_set", 32'(ovf), 1);
        cyc(1, 1, 0, 1, 5);
        chk("prio_ovf_hold", 32'(ovf), 1);
        cyc(0, 1, 0, 1, 0);
        chk("prio_ovf_clr", 32'(ovf), 0);
        chk("prio_fill", 32'(fill), 4);

        // async reset mid-stream with ovf set and fill=3
        cyc(1, 1, 0, 0, 6);
        cyc(0, 1, 1, 0, 0);
        chk("rst_pre_fill", 32'(fill), 3);
        chk("rst_pre_ovf", 32'(ovf), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_async_valid", 32'(m_valid), 0);
        chk("rst_async_fill", 32'(fill), 0);
        chk("rst_async_ovf", 32'(ovf), 0);
        @(negedge clk);
        #1;
        evt_in = 1'b1; cnt_in = 3'd2; m_ready = 1'b0;
        rstn = 1'b1;
        cyc(1, 1, 0, 0, 2);
        chk("rst_after_data", 32'(m_data), 2);
        chk("rst_after_fill", 32'(fill), 1);
        cyc(0, 1, 0, 0, 0);

        // random traffic on a free-running down counter
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0), cnt_in - 3'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/count_capture_fifo.md
Name: count_capture_fifo

Overview:
Downstream consumer of the N-bit down counter: timestamps external events by sampling the live counter value on each event rising edge. Captured values are queued in a small FIFO and drained through a valid/ready interface by the next stage, such as a bus register block or a logger. Overflow on a full FIFO is flagged with a sticky bit.

Parameters:
CNT_W, 3, width of the sampled counter value; 3 matches an 8-state counter.
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  input  1  clock
rstn  input  1  reset
cnt_in  input  CNT_W  live counter value, synchronous to clk
en  input  1  capture enable; when low, event edges are ignored and not queued
evt_in  input  1  event level, synchronous to clk; a capture fires on its 0->1 transition
m_valid  output  1  head entry available
m_ready  input  1  consumer accepts the head entry when m_valid && m_ready at a clk edge
m_data  output  CNT_W  head entry value
fill  output  $clog2(DEPTH+1)  number of stored entries, 0..DEPTH
ovf  output  1  sticky overflow flag
clr_ovf  input  1  clears ovf (synchronous)

Behaviour:
- Reset is rstn, asynchronous, active-low; the clock is clk.
- Reset values:
  - m_valid=0, m_data=0, fill=0, ovf=0.
  - Read and write pointers = 0.
  - Edge-detect register evt_d=0.
  - Storage array is not reset.
- Reset asserted mid-operation discards all entries immediately.
- Edge detect:
  - evt_d <= evt_in every cycle, regardless of en.
  - rise = evt_in && !evt_d.
  - An evt_in held high for many cycles yields one capture.
  - An evt_in already high when reset is released counts as a rise on the first edge.
- Push request: push = rise && en.
  - Value stored = cnt_in sampled at that same clk edge.
- Pop: pop = m_valid && m_ready.
- Latency:
  - An entry pushed at edge N is visible on m_valid/m_data immediately after edge N (one-cycle latency from the event edge).
  - m_data is driven combinationally from the head register, not via an extra output register.
  - m_data = 0 when fill==0.
- Full (fill==DEPTH):
  - Push without a simultaneous pop: the new value is dropped, ovf <= 1, stored entries are unchanged.
  - Push with a simultaneous pop: both occur, fill stays DEPTH, no overflow.
- Empty (fill==0): a pop cannot occur because m_valid=0; m_ready is ignored.
- Push and pop in the same cycle when not full: fill is unchanged, head advances, new entry is appended.
- ovf:
  - Set by a dropped push.
  - Cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, set wins and ovf stays 1.
- Pointers: log2(DEPTH) bits wide, wrap naturally modulo DEPTH.
  - fill is maintained as an explicit counter: +1 on push-only, -1 on pop-only.
- Ordering is strict FIFO; no reordering and no duplication.
- Widths: cnt_in is stored verbatim; no arithmetic is applied to captured data.

Decomposition:
- Package count_capture_pkg:
  - localparams PTR_W = $clog2(DEPTH) and FILL_W = $clog2(DEPTH+1), provided as functions of DEPTH.
  - Elaboration-time check function for the DEPTH power-of-2 rule.
- One sub-module, rise_edge_det:
  - clk, rstn, d in, rise out.
  - Holds the registered evt_d with asynchronous reset to 0.
- FIFO storage and pointer logic stay in the top module.

Test Plan:
- Single capture. CNT_W=3, DEPTH=4, en=1, m_ready=0; counter sequence 0,7,6,5,...; pulse evt_in for 1 cycle while cnt_in=5 -> after that edge m_valid=1, m_data=5, fill=1, ovf=0.
- Level hold. evt_in high for 6 cycles, then en=0 with another pulse -> exactly one entry queued (fill=1); the pulse under en=0 adds nothing.
- Overflow. m_ready=0; five isolated pulses at cnt_in=6,4,2,0,7 -> fill=4, ovf=1. Drain with m_ready=1 -> m_data sequence 6,4,2,0, then m_valid=0 and m_data=0.
- Full push plus pop. With fill=4, assert m_ready=1 in the same cycle as a rise at cnt_in=3 -> fill stays 4, ovf unchanged at 0, last drained entry is 3.
- ovf clear priority. With ovf=1, assert clr_ovf while a drop occurs -> ovf stays 1. Next cycle, clr_ovf alone -> ovf=0.
- Reset mid-stream. With fill=3, pull rstn low asynchronously between edges -> m_valid, fill and ovf go to 0 without waiting for a clock edge. After release, a new pulse at cnt_in=2 -> m_data=2, fill=1.
